// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, keeps one memory request in flight,
// and buffers returned instructions with their addresses in a small prefetch FIFO.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              I_clk,
    input  logic              I_reset,
    output logic              O_mem_req,
    output logic [ADDR_W-1:0] O_mem_addr,
    input  logic              I_mem_ready,
    input  logic [15:0]       I_mem_data,
    output logic [15:0]       O_instruction,
    output logic [ADDR_W-1:0] O_pc,
    output logic              O_valid,
    input  logic              I_next,
    input  logic              I_branch,
    input  logic [ADDR_W-1:0] I_branch_target
);
    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // ST_START is the post-reset state that raises the first request on the next edge.
    typedef enum logic [1:0] {ST_START, ST_IDLE, ST_FETCH, ST_DISCARD} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] redir_q, redir_d;
    logic [15:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic valid, complete, push, pop, flush;

    assign valid    = (cnt_q != '0);
    assign complete = req_q && I_mem_ready;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        redir_d = redir_q;
        push    = 1'b0;
        pop     = valid && I_next;
        flush   = 1'b0;
        if (I_branch) begin
            flush = 1'b1;
            pop   = 1'b0;
            if (!req_q || complete) begin
                addr_d  = I_branch_target;
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end else begin
                // The in-flight request cannot be withdrawn; its data is dropped later.
                state_d = ST_DISCARD;
                redir_d = I_branch_target;
            end
        end else begin
            case (state_q)
                ST_START: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end
                ST_FETCH: begin
                    if (complete) begin
                        push   = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                        if ((cnt_q + CW'(1) - CW'(pop)) >= DEPTH_C) begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                ST_IDLE: begin
                    if ((cnt_q - CW'(pop)) < DEPTH_C) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (complete) begin
                        addr_d  = redir_q;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_START;
            endcase
        end
        cnt_d = flush ? '0 : (cnt_q + CW'(push) - CW'(pop));
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q <= ST_START;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            redir_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            redir_q <= redir_d;
        end
    end

    // Prefetch FIFO: entries carry the instruction word and the address it came from.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            data_q <= '{default: '0};
            pc_q   <= '{default: '0};
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                data_q[wr_q] <= I_mem_data;
                pc_q[wr_q]   <= addr_q;
                wr_q         <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge I_clk) disable iff (I_reset)
        !(push && cnt_q == DEPTH_C));

    assign O_mem_req     = req_q;
    assign O_mem_addr    = addr_q;
    assign O_valid       = valid;
    assign O_instruction = data_q[rd_q];
    assign O_pc          = pc_q[rd_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns 0x1000 + address.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready, next, branch;
    logic [15:0] target;
    logic        req, valid;
    logic [15:0] addr, instr, pc, mdata;
    logic        ready2, next2, branch2;
    logic [15:0] target2;
    logic        req2, valid2;
    logic [15:0] addr2, instr2, pc2, mdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mdata  = 16'h1000 + addr;
    assign mdata2 = 16'h1000 + addr2;

    fetch_unit dut (
        .I_clk(clk), .I_reset(rst), .O_mem_req(req), .O_mem_addr(addr),
        .I_mem_ready(ready), .I_mem_data(mdata), .O_instruction(instr), .O_pc(pc),
        .O_valid(valid), .I_next(next), .I_branch(branch), .I_branch_target(target)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .I_clk(clk), .I_reset(rst), .O_mem_req(req2), .O_mem_addr(addr2),
        .I_mem_ready(ready2), .I_mem_data(mdata2), .O_instruction(instr2), .O_pc(pc2),
        .O_valid(valid2), .I_next(next2), .I_branch(branch2), .I_branch_target(target2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1; ready = 1'b1; next = 1'b0; branch = 1'b0; target = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ready = 1'b1; next = 1'b0; branch = 1'b0; target = '0;
        tick;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h want 0000", instr); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want 0000", pc); end
        tick;
        rst = 1'b0;
        tick;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", req); end
        checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL first_addr: got %h want 0000", addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_valid: got %b want 0", valid); end
        tick;
        checks++; if (addr !== 16'h0001) begin errors++; $display("FAIL second_addr: got %h want 0001", addr); end
        checks++; if (valid !== 1'b1 || pc !== 16'h0000 || instr !== 16'h1000) begin
            errors++; $display("FAIL first_push: valid %b pc %h instr %h want 1 0000 1000", valid, pc, instr); end
        tick;
        checks++; if (req !== 1'b0 || addr !== 16'h0002) begin
            errors++; $display("FAIL full_stop: req %b addr %h want 0 0002", req, addr); end
        repeat (4) tick;
        checks++; if (req !== 1'b0 || valid !== 1'b1 || pc !== 16'h0000 || instr !== 16'h1000) begin
            errors++; $display("FAIL hold_head: req %b valid %b pc %h instr %h want 0 1 0000 1000", req, valid, pc, instr); end
    endtask

    task automatic test_streaming;
        reset_dut;
        next = 1'b1;
        tick; tick;
        for (int i = 0; i < 8; i++) begin
            checks++; if (valid !== 1'b1 || pc !== 16'(i) || instr !== 16'(16'h1000 + i)) begin
                errors++; $display("FAIL stream[%0d]: valid %b pc %h instr %h want 1 %h %h", i, valid, pc, instr, 16'(i), 16'(16'h1000 + i)); end
            tick;
        end
    endtask

    task automatic test_wait_states;
        int          exp_pc;
        logic        p_req, p_ready;
        logic [15:0] p_addr;
        exp_pc = 0;
        reset_dut;
        next = 1'b1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            ready = (cyc % 3 == 2);
            p_req = req; p_addr = addr; p_ready = ready;
            if (valid) begin
                checks++; if (pc !== 16'(exp_pc) || instr !== 16'(16'h1000 + exp_pc)) begin
                    errors++; $display("FAIL wait_order: pc %h instr %h want %h %h", pc, instr, 16'(exp_pc), 16'(16'h1000 + exp_pc)); end
                exp_pc++;
            end
            tick;
            if (p_req && !p_ready) begin
                checks++; if (req !== 1'b1 || addr !== p_addr) begin
                    errors++; $display("FAIL wait_hold: req %b addr %h want 1 %h", req, addr, p_addr); end
            end
        end
        checks++; if (exp_pc != 11) begin errors++; $display("FAIL wait_count: popped %0d want 11", exp_pc); end
        ready = 1'b1;
    endtask

    task automatic test_branch_discard;
        reset_dut;
        next = 1'b1;
        repeat (6) tick;
        checks++; if (addr !== 16'h0005 || valid !== 1'b1) begin
            errors++; $display("FAIL disc_setup: addr %h valid %b want 0005 1", addr, valid); end
        ready = 1'b0; branch = 1'b1; target = 16'h0040; next = 1'b0;
        tick;
        branch = 1'b0;
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0005) begin
            errors++; $display("FAIL disc_enter: valid %b req %b addr %h want 0 1 0005", valid, req, addr); end
        tick;
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0005) begin
            errors++; $display("FAIL disc_wait: valid %b req %b addr %h want 0 1 0005", valid, req, addr); end
        ready = 1'b1;
        tick;
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0040) begin
            errors++; $display("FAIL disc_drop: valid %b req %b addr %h want 0 1 0040", valid, req, addr); end
        tick;
        checks++; if (valid !== 1'b1 || pc !== 16'h0040 || instr !== 16'h1040) begin
            errors++; $display("FAIL disc_target: valid %b pc %h instr %h want 1 0040 1040", valid, pc, instr); end
    endtask

    task automatic test_double_branch;
        reset_dut;
        next = 1'b1;
        repeat (6) tick;
        ready = 1'b0; branch = 1'b1; target = 16'h0040; next = 1'b0;
        tick;
        target = 16'h0080;
        tick;
        branch = 1'b0;
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0005) begin
            errors++; $display("FAIL dbl_hold: valid %b req %b addr %h want 0 1 0005", valid, req, addr); end
        ready = 1'b1;
        tick;
        checks++; if (addr !== 16'h0080 || valid !== 1'b0) begin
            errors++; $display("FAIL dbl_redir: addr %h valid %b want 0080 0", addr, valid); end
        tick;
        checks++; if (valid !== 1'b1 || pc !== 16'h0080 || instr !== 16'h1080) begin
            errors++; $display("FAIL dbl_target: valid %b pc %h instr %h want 1 0080 1080", valid, pc, instr); end
    endtask

    task automatic test_back_to_back;
        reset_dut;
        next = 1'b1;
        repeat (4) tick;
        checks++; if (valid !== 1'b1 || pc !== 16'h0002) begin
            errors++; $display("FAIL b2b_setup: valid %b pc %h want 1 0002", valid, pc); end
        branch = 1'b1; target = 16'h0020;
        tick;
        branch = 1'b0;
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 16'h0020) begin
            errors++; $display("FAIL b2b_flush: valid %b req %b addr %h want 0 1 0020", valid, req, addr); end
        tick;
        checks++; if (valid !== 1'b1 || pc !== 16'h0020 || instr !== 16'h1020) begin
            errors++; $display("FAIL b2b_first: valid %b pc %h instr %h want 1 0020 1020", valid, pc, instr); end
        tick;
        checks++; if (valid !== 1'b1 || pc !== 16'h0021 || instr !== 16'h1021) begin
            errors++; $display("FAIL b2b_second: valid %b pc %h instr %h want 1 0021 1021", valid, pc, instr); end
    endtask

    task automatic test_wrap;
        reset_dut;
        tick;
        checks++; if (req2 !== 1'b1 || addr2 !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_req: req %b addr %h want 1 ffff", req2, addr2); end
        tick;
        checks++; if (valid2 !== 1'b1 || pc2 !== 16'hFFFF || instr2 !== 16'h0FFF) begin
            errors++; $display("FAIL wrap_first: valid %b pc %h instr %h want 1 ffff 0fff", valid2, pc2, instr2); end
        tick;
        checks++; if (valid2 !== 1'b1 || pc2 !== 16'h0000 || instr2 !== 16'h1000) begin
            errors++; $display("FAIL wrap_second: valid %b pc %h instr %h want 1 0000 1000", valid2, pc2, instr2); end
    endtask

    task automatic test_async_reset;
        reset_dut;
        tick; tick;
        ready = 1'b0;
        tick;
        checks++; if (req !== 1'b1 || valid !== 1'b1 || addr !== 16'h0001) begin
            errors++; $display("FAIL ar_setup: req %b valid %b addr %h want 1 1 0001", req, valid, addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (req !== 1'b0 || valid !== 1'b0 || addr !== 16'h0000) begin
            errors++; $display("FAIL ar_immediate: req %b valid %b addr %h want 0 0 0000", req, valid, addr); end
        tick;
        rst = 1'b0; ready = 1'b1;
        tick;
        checks++; if (req !== 1'b1 || addr !== 16'h0000 || valid !== 1'b0) begin
            errors++; $display("FAIL ar_restart: req %b addr %h valid %b want 1 0000 0", req, addr, valid); end
        tick;
        checks++; if (valid !== 1'b1 || pc !== 16'h0000 || instr !== 16'h1000) begin
            errors++; $display("FAIL ar_first: valid %b pc %h instr %h want 1 0000 1000", valid, pc, instr); end
    endtask

    initial begin
        ready2 = 1'b1; next2 = 1'b1; branch2 = 1'b0; target2 = '0;
        test_reset;
        test_streaming;
        test_wait_states;
        test_branch_discard;
        test_double_branch;
        test_back_to_back;
        test_wrap;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
